// File: rtl/ctl_link_pkg.sv
// ---------------------------------------------------------------------------
// ctl_link_pkg
// Shared definitions for the serial control link (transmitter and receiver).
//   FRAME_BITS / OP_W / DATA_W : frame geometry (start + op + data + parity + stop)
//   ctl_state_e                : framer state sequence
//   ctl_word_t                 : packed {op, data} control word
//   ctl_serial_order()         : payload arranged so bit 0 leaves the line first
//   ctl_parity()               : even parity over the 24 payload bits
// ---------------------------------------------------------------------------
package ctl_link_pkg;

    localparam int unsigned FRAME_BITS = 27;
    localparam int unsigned OP_W       = 4;
    localparam int unsigned DATA_W     = 20;
    localparam int unsigned PAYLOAD_W  = OP_W + DATA_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        OP    = 3'd2,
        DATA  = 3'd3,
        PAR   = 3'd4,
        STOP  = 3'd5
    } ctl_state_e;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] data;
    } ctl_word_t;

    // Opcode occupies the low bits so a right-shifting register emits
    // op[0..3] followed by data[0..19].
    function automatic logic [PAYLOAD_W-1:0] ctl_serial_order(input ctl_word_t w);
        return {w.data, w.op};
    endfunction

    // XOR of all payload bits: payload plus this bit holds an even count of ones.
    function automatic logic ctl_parity(input ctl_word_t w);
        return ^w;
    endfunction

endpackage

// File: rtl/ctl_frame_tx_bit_timer.sv
// ---------------------------------------------------------------------------
// bit_timer
// DIV-cycle down-counter marking the end of each serial bit period.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset (counter cleared)
//   restart_i : reload the counter; the next tick comes DIV cycles later
//   tick_o    : high in the last cycle of each DIV-cycle bit period
// ---------------------------------------------------------------------------
module bit_timer #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    output logic tick_o
);

    localparam int unsigned    CW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  RELOAD = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (restart_i || (cnt_q == '0)) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // A restart in the same cycle suppresses the tick so the new period
    // always lasts the full DIV cycles.
    assign tick_o = (cnt_q == '0) & ~restart_i;

endmodule

// File: rtl/ctl_frame_tx.sv
// ---------------------------------------------------------------------------
// ctl_frame_tx
// Serial control-frame transmitter: start(0), op[0..3], data[0..19],
// even parity, stop(1); each bit held for DIV clock cycles.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   in_valid : host offers a word
//   in_ready : word can be accepted this cycle (idle and not aborting)
//   in_op    : opcode, sampled on handshake
//   in_data  : data word, sampled on handshake
//   abort    : synchronous cancel of the frame in progress
//   tx       : registered serial line, idles high
//   busy     : frame in progress
//   done     : one-cycle pulse after a frame completes normally
// ---------------------------------------------------------------------------
module ctl_frame_tx
    import ctl_link_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_W-1:0]     in_op,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                abort,
    output logic                tx,
    output logic                busy,
    output logic                done
);

    localparam logic [4:0] OP_LAST   = 5'(OP_W - 1);
    localparam logic [4:0] DATA_LAST = 5'(DATA_W - 1);

    ctl_state_e             state_q;
    logic [PAYLOAD_W-1:0]   shift_q;
    logic                   par_q;
    logic [4:0]             idx_q;
    logic                   tx_q;
    logic                   done_q;

    ctl_word_t              word;
    logic                   hs;
    logic                   tick;

    assign word     = {in_op, in_data};
    assign in_ready = (state_q == IDLE) & ~abort;
    assign hs       = in_valid & in_ready;

    bit_timer #(
        .DIV (DIV)
    ) u_bit_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart_i (hs),
        .tick_o    (tick)
    );

    // tx_q is loaded with the bit for the state being entered, so the line
    // changes on the same edge as the state and stays glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            par_q   <= 1'b0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if ((state_q != IDLE) && abort) begin
                // Shift register is left as is; it is reloaded on the next handshake.
                state_q <= IDLE;
                tx_q    <= 1'b1;
                idx_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (hs) begin
                            shift_q <= ctl_serial_order(word);
                            par_q   <= ctl_parity(word);
                            idx_q   <= '0;
                            tx_q    <= 1'b0;
                            state_q <= START;
                        end
                    end
                    START: begin
                        if (tick) begin
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                            idx_q   <= '0;
                            state_q <= OP;
                        end
                    end
                    OP: begin
                        if (tick) begin
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                            if (idx_q == OP_LAST) begin
                                idx_q   <= '0;
                                state_q <= DATA;
                            end else begin
                                idx_q   <= idx_q + 5'd1;
                            end
                        end
                    end
                    DATA: begin
                        if (tick) begin
                            if (idx_q == DATA_LAST) begin
                                tx_q    <= par_q;
                                idx_q   <= '0;
                                state_q <= PAR;
                            end else begin
                                tx_q    <= shift_q[0];
                                shift_q <= shift_q >> 1;
                                idx_q   <= idx_q + 5'd1;
                            end
                        end
                    end
                    PAR: begin
                        if (tick) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end
                    end
                    STOP: begin
                        if (tick) begin
                            tx_q    <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                    default: begin
                        tx_q    <= 1'b1;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_ctl_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_ctl_frame_tx
// Self-checking bench for ctl_frame_tx (DIV = 4). A frame-level model
// (27-entry bit array plus elapsed-cycle counter) predicts tx/busy/done/in_ready
// every cycle; directed sequences pin the model with hand-computed frames.
// ---------------------------------------------------------------------------
module tb_ctl_frame_tx;

    localparam int unsigned DIV = 4;
    localparam int          FB  = 27;
    localparam int          FL  = FB * DIV;   // cycles per frame

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        in_valid = 1'b0;
    logic        abort    = 1'b0;
    logic [3:0]  in_op    = '0;
    logic [19:0] in_data  = '0;
    logic        in_ready;
    logic        tx;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    ctl_frame_tx #(.DIV(DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_data  (in_data),
        .abort    (abort),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    logic m_active = 1'b0;
    logic m_done   = 1'b0;
    logic m_hs     = 1'b0;
    int   m_t      = 0;       // cycles elapsed since the accepting edge
    logic m_bits [FB];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_hs     <= 1'b0;
            m_t      <= 0;
        end else begin
            m_done <= 1'b0;
            m_hs   <= 1'b0;
            if (m_active) begin
                if (abort) begin
                    m_active <= 1'b0;
                end else if (m_t + 1 == FL) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                end else begin
                    m_t <= m_t + 1;
                end
            end else if (in_valid && !abort) begin
                m_active <= 1'b1;
                m_hs     <= 1'b1;
                m_t      <= 0;
                m_bits[0] <= 1'b0;
                for (int i = 0; i < 4; i++)  m_bits[1 + i] <= in_op[i];
                for (int i = 0; i < 20; i++) m_bits[5 + i] <= in_data[i];
                m_bits[25] <= (($countones({in_op, in_data}) & 1) == 1);
                m_bits[26] <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("tx",       tx,       m_active ? m_bits[m_t / DIV] : 1'b1);
            chk("busy",     busy,     m_active);
            chk("done",     done,     m_done);
            chk("in_ready", in_ready, !m_active && !abort);
        end
    end

    // Called just after an edge E: offers a word, captures one sample per bit,
    // and reports the edge (counted from E) after which done is high.
    task automatic send_capture(input logic [3:0] op, input logic [19:0] d,
                                output logic [26:0] bits, output int done_edge);
        int   cur;
        int   hse;
        logic r;
        cur = 0; hse = -1; done_edge = -1; bits = '0;
        in_op = op; in_data = d; in_valid = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk); r = in_ready;
            @(posedge clk); cur++;
            if (r) begin hse = cur; break; end
        end
        #1 in_valid = 1'b0;
        in_op = 4'($urandom); in_data = 20'($urandom);
        if (hse < 0) return;
        for (int k = 0; k < FB; k++) begin
            while (cur < hse + k * DIV + 1) begin @(posedge clk); cur++; end
            @(negedge clk); bits[k] = tx;
        end
        for (int t = 0; t < 4 * DIV; t++) begin
            @(posedge clk); cur++;
            @(negedge clk);
            if (done) begin done_edge = cur; break; end
        end
    endtask

    logic [26:0] bits;
    int          de, cur, hsd, nd, nh;
    int          hs_e[2];
    int          dn_e[2];
    logic        r;

    initial begin
        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("rst_tx", tx, 1'b1);
            chk("rst_ready", in_ready, 1'b1);
            chk("rst_busy", busy, 1'b0);
        end

        // ---------------- single frame op=A data=1 ----------------
        @(posedge clk); #1;
        send_capture(4'hA, 20'h00001, bits, de);
        chk("frame_A", bits, 27'h6000034);
        chk("done_lat_A", de, 109);

        // ---------------- all-zero payload ----------------
        @(posedge clk); #1;
        send_capture(4'h0, 20'h00000, bits, de);
        chk("frame_zero", bits, 27'h4000000);
        chk("done_lat_zero", de, 1 + FL);

        // ---------------- back-to-back ----------------
        @(posedge clk); #1;
        in_op = 4'h1; in_data = 20'h12345; in_valid = 1'b1;
        cur = 0; nh = 0; nd = 0;
        hs_e[0] = -1000; hs_e[1] = -1000; dn_e[0] = -1000; dn_e[1] = -1000;
        for (int t = 0; t < 400 && nd < 2; t++) begin
            @(negedge clk);
            if (done) begin dn_e[nd] = cur; nd++; end
            r = in_ready;
            @(posedge clk); cur++;
            if (r && in_valid && nh < 2) begin
                hs_e[nh] = cur; nh++;
                #1;
                if (nh == 1) begin in_op = 4'h6; in_data = 20'hABCDE; end
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("b2b_first_len", dn_e[0] - hs_e[0], FL);
        chk("b2b_gap",       hs_e[1] - dn_e[0], 1);
        chk("b2b_spacing",   hs_e[1] - hs_e[0], FL + 1);
        chk("b2b_total",     dn_e[1] - hs_e[0] + 1, 2 * FL + 2);

        // ---------------- abort in DATA bit 7 ----------------
        @(posedge clk); #1;
        in_op = 4'h5; in_data = 20'h0F0F0; in_valid = 1'b1;
        cur = 0; hsd = -1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk); r = in_ready;
            @(posedge clk); cur++;
            if (r) begin hsd = cur; break; end
        end
        #1 in_valid = 1'b0;
        chk("abort_hs", hsd > 0, 1'b1);
        while (cur < hsd + 12 * DIV + 1) begin @(posedge clk); cur++; end
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_tx",   tx,   1'b1);
        nd = 0;
        repeat (30 * DIV) begin @(negedge clk); if (done) nd++; end
        chk("abort_no_done", nd, 0);
        @(posedge clk); #1;
        send_capture(4'hF, 20'hFFFFF, bits, de);
        chk("frame_ones", bits, 27'h5FFFFFE);
        chk("done_lat_ones", de, 1 + FL);

        // ---------------- abort on the final STOP cycle ----------------
        @(posedge clk); #1;
        in_op = 4'h9; in_data = 20'h5A5A5; in_valid = 1'b1;
        cur = 0; hsd = -1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk); r = in_ready;
            @(posedge clk); cur++;
            if (r) begin hsd = cur; break; end
        end
        #1 in_valid = 1'b0;
        while (cur < hsd + FL - 1) begin @(posedge clk); cur++; end
        #1 abort = 1'b1;
        @(negedge clk);
        chk("stop_abort_busy_before", busy, 1'b1);
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("stop_abort_done",  done,     1'b0);
        chk("stop_abort_ready", in_ready, 1'b1);
        chk("stop_abort_busy",  busy,     1'b0);

        // ---------------- random traffic ----------------
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            if (in_valid && m_hs) in_valid = 1'b0;
            if (!in_valid) begin
                in_op   = 4'($urandom);
                in_data = 20'($urandom);
                if ($urandom_range(0, 3) == 0) in_valid = 1'b1;
            end
            abort = ($urandom_range(0, 299) == 0);
        end
        @(posedge clk); #1 in_valid = 1'b0; abort = 1'b0;
        repeat (FL + 10) @(posedge clk);

        // ---------------- asynchronous reset mid-frame ----------------
        #1 in_op = 4'h3; in_data = 20'h00F00; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (40) @(posedge clk);
        #3;
        chk("pre_reset_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_tx",    tx,       1'b1);
        chk("async_rst_busy",  busy,     1'b0);
        chk("async_rst_ready", in_ready, 1'b1);
        chk("async_rst_done",  done,     1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
